decode_queue: RTL and testbench

Parametrised decode stage with a buffered output. It accepts raw RV32I instructions and their PC from fetch over a valid/ready handshake, and splits each instruction into register indices, funct fields and a sign-extended immediate. Decoded entries go into a DEPTH-entry FIFO that feeds execute over a second valid/ready handshake. The FIFO decouples fetch from execute stalls and supports a single-cycle flush for branch redirects.

---
 rtl/decode_queue.sv | 185 ++++++++++++++++++
 tb/tb_decode_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: RV32I field decode feeding a DEPTH-entry FIFO toward execute.
// Optional macro DECODE_ILLEGAL_EN stores and reports a per-entry illegal-opcode flag.
module decode_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [31:0]                in_inst_i,
   input  logic [XLEN-1:0]            in_pc_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [XLEN-1:0]            out_pc_o,
   output logic [6:0]                 out_opcode_o,
   output logic [2:0]                 out_funct3_o,
   output logic [6:0]                 out_funct7_o,
   output logic [4:0]                 out_rs1_idx_o,
   output logic [4:0]                 out_rs2_idx_o,
   output logic [4:0]                 out_rd_idx_o,
   output logic [XLEN-1:0]            out_imm_o,
   output logic                       out_illegal_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
   } entry_t;

   entry_t        dec;
   logic [31:0]   imm32;
   entry_t        mem [DEPTH];
   entry_t        head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          push;
   logic          pop;

   // Field extraction; any field an opcode does not list stays 0.
   always_comb begin
      dec        = '0;
      imm32      = '0;
      dec.pc     = in_pc_i;
      dec.opcode = in_inst_i[6:0];
      case (in_inst_i[6:0])
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
            dec.rs1    = in_inst_i[19:15];
            dec.funct3 = in_inst_i[14:12];
            dec.rd     = in_inst_i[11:7];
            imm32      = {{20{in_inst_i[31]}}, in_inst_i[31:20]};
         end
         OPC_STORE: begin
            dec.rs1    = in_inst_i[19:15];
            dec.rs2    = in_inst_i[24:20];
            dec.funct3 = in_inst_i[14:12];
            imm32      = {{20{in_inst_i[31]}}, in_inst_i[31:25], in_inst_i[11:7]};
         end
         OPC_OP: begin
            dec.funct7 = in_inst_i[31:25];
            dec.rs1    = in_inst_i[19:15];
            dec.rs2    = in_inst_i[24:20];
            dec.funct3 = in_inst_i[14:12];
            dec.rd     = in_inst_i[11:7];
         end
         OPC_BRANCH: begin
            dec.rs1    = in_inst_i[19:15];
            dec.rs2    = in_inst_i[24:20];
            dec.funct3 = in_inst_i[14:12];
            imm32      = {{19{in_inst_i[31]}}, in_inst_i[31], in_inst_i[7],
                          in_inst_i[30:25], in_inst_i[11:8], 1'b0};
         end
         OPC_JAL: begin
            dec.rd = in_inst_i[11:7];
            imm32  = {{11{in_inst_i[31]}}, in_inst_i[31], in_inst_i[19:12],
                      in_inst_i[20], in_inst_i[30:21], 1'b0};
         end
         OPC_AUIPC, OPC_LUI: begin
            dec.rd = in_inst_i[11:7];
            imm32  = {in_inst_i[31:12], 12'b0};
         end
         default: begin
            imm32 = '0;
         end
      endcase
      dec.imm = XLEN'($signed(imm32));
   end

   // Handshake: a transfer completes at a rising edge where valid && ready are both
   // high and flush_i is low; in_ready_o depends only on registered occupancy.
   assign in_ready_o  = count_q < CW'(DEPTH);
   assign out_valid_o = count_q != '0;
   assign push        = in_valid_i && in_ready_o && !flush_i;
   assign pop         = out_valid_o && out_ready_i && !flush_i;
   assign count_o     = count_q;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= dec;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (push && !pop) begin
            count_q <= count_q + CW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   assign head = mem[rd_ptr];

   // Stale storage must never leak onto the execute bus while empty.
   assign out_pc_o      = out_valid_o ? head.pc     : '0;
   assign out_opcode_o  = out_valid_o ? head.opcode : '0;
   assign out_funct3_o  = out_valid_o ? head.funct3 : '0;
   assign out_funct7_o  = out_valid_o ? head.funct7 : '0;
   assign out_rs1_idx_o = out_valid_o ? head.rs1    : '0;
   assign out_rs2_idx_o = out_valid_o ? head.rs2    : '0;
   assign out_rd_idx_o  = out_valid_o ? head.rd     : '0;
   assign out_imm_o     = out_valid_o ? head.imm    : '0;

`ifdef DECODE_ILLEGAL_EN
   logic             dec_illegal;
   logic [DEPTH-1:0] ill_mem;

   // Every recognised opcode ends in 2'b11, so a bad low pair is also caught here.
   assign dec_illegal = !(in_inst_i[6:0] inside {OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP,
                                                  OPC_BRANCH, OPC_JAL, OPC_JALR,
                                                  OPC_AUIPC, OPC_LUI});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ill_mem <= '0;
      end else if (push) begin
         ill_mem[wr_ptr] <= dec_illegal;
      end
   end

   assign out_illegal_o = out_valid_o && ill_mem[rd_ptr];
`else
   assign out_illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios plus random traffic against a queue-based model.
// Honours DECODE_ILLEGAL_EN when computing the expected illegal flag.
module tb_decode_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 3;
   localparam int CW    = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic            illegal;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush_i;
   logic            in_valid_i;
   logic            in_ready_o;
   logic [31:0]     in_inst_i;
   logic [XLEN-1:0] in_pc_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [XLEN-1:0] out_pc_o;
   logic [6:0]      out_opcode_o;
   logic [2:0]      out_funct3_o;
   logic [6:0]      out_funct7_o;
   logic [4:0]      out_rs1_idx_o;
   logic [4:0]      out_rs2_idx_o;
   logic [4:0]      out_rd_idx_o;
   logic [XLEN-1:0] out_imm_o;
   logic            out_illegal_o;
   logic [CW-1:0]   count_o;

   exp_t obs;
   exp_t exp_q[$];
   int   asserts = 0;
   int   fails   = 0;

   decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_inst_i(in_inst_i), .in_pc_i(in_pc_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_pc_o(out_pc_o), .out_opcode_o(out_opcode_o),
      .out_funct3_o(out_funct3_o), .out_funct7_o(out_funct7_o),
      .out_rs1_idx_o(out_rs1_idx_o), .out_rs2_idx_o(out_rs2_idx_o),
      .out_rd_idx_o(out_rd_idx_o), .out_imm_o(out_imm_o),
      .out_illegal_o(out_illegal_o), .count_o(count_o)
   );

   assign obs = {out_pc_o, out_opcode_o, out_funct3_o, out_funct7_o, out_rs1_idx_o,
                 out_rs2_idx_o, out_rd_idx_o, out_imm_o, out_illegal_o};

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, fails=%0d", fails);
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic exp_t ref_decode(input logic [31:0] inst, input logic [XLEN-1:0] pc);
      exp_t e;
      int   s;
      byte  fmt;
      e        = '0;
      e.pc     = pc;
      e.opcode = inst[6:0];
      s        = 0;
      case (inst[6:0])
         7'h03, 7'h13, 7'h67: fmt = "I";
         7'h23: fmt = "S";
         7'h33: fmt = "R";
         7'h63: fmt = "B";
         7'h6F: fmt = "J";
         7'h17, 7'h37: fmt = "U";
         default: fmt = "X";
      endcase
      if (fmt inside {"I", "S", "R", "B"}) begin
         e.rs1    = inst[19:15];
         e.funct3 = inst[14:12];
      end
      if (fmt inside {"S", "R", "B"}) e.rs2 = inst[24:20];
      if (fmt inside {"I", "R", "J", "U"}) e.rd = inst[11:7];
      if (fmt == "R") e.funct7 = inst[31:25];
      case (fmt)
         "I": s = $signed(inst) >>> 20;
         "S": s = (($signed(inst) >>> 25) * 32) + int'(inst[11:7]);
         "B": s = (($signed(inst) >>> 31) * 4096) + int'(inst[7]) * 2048
                  + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
         "J": s = (($signed(inst) >>> 31) * (1 << 20)) + int'(inst[19:12]) * 4096
                  + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
         "U": s = $signed(inst & 32'hFFFF_F000);
         default: s = 0;
      endcase
      e.imm = XLEN'(s);
`ifdef DECODE_ILLEGAL_EN
      e.illegal = (fmt == "X");
`else
      e.illegal = 1'b0;
`endif
      return e;
   endfunction

   function automatic exp_t exp_head();
      return (exp_q.size() != 0) ? exp_q[0] : '0;
   endfunction

   function automatic logic [31:0] gen_inst();
      logic [31:0] r;
      logic [6:0]  opc [11];
      opc = '{7'h03, 7'h23, 7'h13, 7'h33, 7'h63, 7'h6F, 7'h67, 7'h17, 7'h37, 7'h7F, 7'h10};
      r = $urandom();
      r[6:0] = opc[$urandom_range(0, 10)];
      return r;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input logic [31:0] inst, input logic [XLEN-1:0] pc,
                        input logic rdy, input logic fl);
      @(negedge clk);
      in_valid_i  = v;
      in_inst_i   = inst;
      in_pc_i     = pc;
      out_ready_i = rdy;
      flush_i     = fl;
   endtask

   // Applies this cycle's handshake outcome to the model, then lets the edge happen.
   task automatic commit();
      bit do_push;
      bit do_pop;
      do_push = in_valid_i && (exp_q.size() < DEPTH) && !flush_i;
      do_pop  = (exp_q.size() != 0) && out_ready_i && !flush_i;
      if (flush_i) begin
         exp_q.delete();
      end else begin
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) exp_q.push_back(ref_decode(in_inst_i, in_pc_i));
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      in_valid_i = 0; in_inst_i = '0; in_pc_i = '0; out_ready_i = 0; flush_i = 0;
      repeat (2) @(negedge clk);
      asserts++;
      if (count_o !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", count_o); end
      asserts++;
      if (out_valid_o !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid_o); end
      asserts++;
      if (in_ready_o !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready_o); end
      asserts++;
      if (obs !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", obs); end
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_addi();
      drive(1, 32'h00A0_0093, XLEN'(32'h100), 1, 0);
      asserts++;
      if (in_ready_o !== 1'b1) begin fails++; $display("FAIL addi_in_ready: got %b want 1", in_ready_o); end
      commit();
      drive(0, '0, '0, 1, 0);
      asserts++;
      if (out_valid_o !== 1'b1) begin fails++; $display("FAIL addi_latency: out_valid got %b want 1", out_valid_o); end
      asserts++;
      if ({out_rd_idx_o, out_rs1_idx_o, out_funct3_o, out_opcode_o} !== {5'd1, 5'd0, 3'd0, 7'h13}) begin
         fails++;
         $display("FAIL addi_fields: rd=%0d rs1=%0d f3=%0d opc=%h want 1 0 0 13",
                  out_rd_idx_o, out_rs1_idx_o, out_funct3_o, out_opcode_o);
      end
      asserts++;
      if (out_imm_o !== XLEN'(10)) begin fails++; $display("FAIL addi_imm: got %h want a", out_imm_o); end
      asserts++;
      if (obs !== exp_head()) begin fails++; $display("FAIL addi_entry: got %h want %h", obs, exp_head()); end
      commit();
   endtask

   task automatic test_branch();
      drive(1, 32'hFE00_0EE3, XLEN'(32'h104), 0, 0);
      commit();
      drive(0, '0, '0, 1, 0);
      asserts++;
      if (out_imm_o !== XLEN'(32'hFFFF_FFFC)) begin fails++; $display("FAIL beq_imm: got %h want fffffffc", out_imm_o); end
      asserts++;
      if ({out_rs1_idx_o, out_rs2_idx_o, out_rd_idx_o} !== 15'd0) begin
         fails++;
         $display("FAIL beq_regs: rs1=%0d rs2=%0d rd=%0d want 0 0 0", out_rs1_idx_o, out_rs2_idx_o, out_rd_idx_o);
      end
      asserts++;
      if (obs !== exp_head()) begin fails++; $display("FAIL beq_entry: got %h want %h", obs, exp_head()); end
      commit();
   endtask

   task automatic test_full();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, gen_inst(), XLEN'(32'h200 + 4 * i), 0, 0);
         commit();
      end
      drive(0, '0, '0, 0, 0);
      asserts++;
      if (in_ready_o !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b want 0", in_ready_o); end
      asserts++;
      if (count_o !== CW'(DEPTH)) begin fails++; $display("FAIL full_count: got %0d want %0d", count_o, DEPTH); end
      drive(1, gen_inst(), XLEN'(32'h2F0), 1, 0);
      asserts++;
      if (in_ready_o !== 1'b0) begin fails++; $display("FAIL full_pushpop_ready: got %b want 0", in_ready_o); end
      commit();
      drive(0, '0, '0, 0, 0);
      asserts++;
      if (count_o !== CW'(DEPTH - 1)) begin fails++; $display("FAIL full_after_pop_count: got %0d want %0d", count_o, DEPTH - 1); end
      for (int i = 1; i < DEPTH; i++) begin
         drive(0, '0, '0, 1, 0);
         asserts++;
         if (out_pc_o !== XLEN'(32'h200 + 4 * i)) begin
            fails++; $display("FAIL full_order: got pc %h want %h", out_pc_o, 32'h200 + 4 * i);
         end
         asserts++;
         if (obs !== exp_head()) begin fails++; $display("FAIL full_entry: got %h want %h", obs, exp_head()); end
         commit();
      end
   endtask

   task automatic test_stream();
      int pushed = 0;
      int popped = 0;
      int cyc    = 0;
      logic v, rdy;
      while ((pushed < 10 || exp_q.size() != 0) && cyc < 100) begin
         v   = (pushed < 10);
         rdy = cyc[0];
         drive(v, gen_inst(), XLEN'(32'h1000 + 4 * pushed), rdy, 0);
         asserts++;
         if (obs !== exp_head()) begin fails++; $display("FAIL stream_entry: cyc %0d got %h want %h", cyc, obs, exp_head()); end
         asserts++;
         if (count_o !== CW'(exp_q.size())) begin fails++; $display("FAIL stream_count: got %0d want %0d", count_o, exp_q.size()); end
         if (exp_q.size() != 0 && rdy) begin
            asserts++;
            if (out_pc_o !== XLEN'(32'h1000 + 4 * popped)) begin
               fails++; $display("FAIL stream_pc_order: got %h want %h", out_pc_o, 32'h1000 + 4 * popped);
            end
            popped++;
         end
         if (v && exp_q.size() < DEPTH) pushed++;
         commit();
         cyc++;
      end
      asserts++;
      if (popped != 10 || pushed != 10) begin
         fails++; $display("FAIL stream_complete: pushed %0d popped %0d want 10 10 within 100 cycles", pushed, popped);
      end
   endtask

   task automatic test_flush();
      drive(1, gen_inst(), XLEN'(32'h300), 0, 0); commit();
      drive(1, gen_inst(), XLEN'(32'h304), 0, 0); commit();
      drive(1, gen_inst(), XLEN'(32'h308), 1, 1);
      asserts++;
      if (count_o !== CW'(2)) begin fails++; $display("FAIL flush_pre_count: got %0d want 2", count_o); end
      commit();
      drive(0, '0, '0, 0, 0);
      asserts++;
      if (count_o !== '0 || out_valid_o !== 1'b0) begin
         fails++; $display("FAIL flush_empty: count %0d valid %b want 0 0", count_o, out_valid_o);
      end
      asserts++;
      if (obs !== '0) begin fails++; $display("FAIL flush_outputs: got %h want 0", obs); end
      drive(1, 32'h0000_0537, XLEN'(32'h400), 0, 0); commit();
      drive(0, '0, '0, 1, 0);
      asserts++;
      if (count_o !== CW'(1) || out_pc_o !== XLEN'(32'h400)) begin
         fails++; $display("FAIL flush_repush: count %0d pc %h want 1 400", count_o, out_pc_o);
      end
      asserts++;
      if (obs !== exp_head()) begin fails++; $display("FAIL flush_repush_entry: got %h want %h", obs, exp_head()); end
      commit();
   endtask

   task automatic test_illegal();
      logic want_ill;
`ifdef DECODE_ILLEGAL_EN
      want_ill = 1'b1;
`else
      want_ill = 1'b0;
`endif
      drive(1, 32'h0000_007F, XLEN'(32'h500), 0, 0); commit();
      drive(0, '0, '0, 1, 0);
      asserts++;
      if (out_illegal_o !== want_ill) begin fails++; $display("FAIL illegal_flag: got %b want %b", out_illegal_o, want_ill); end
      asserts++;
      if ({out_funct3_o, out_funct7_o, out_rs1_idx_o, out_rs2_idx_o, out_rd_idx_o, out_imm_o} !== '0
          || out_opcode_o !== 7'h7F) begin
         fails++; $display("FAIL illegal_fields: got %h want opcode 7f and zero fields", obs);
      end
      commit();
   endtask

   task automatic test_async_reset();
      drive(1, gen_inst(), XLEN'(32'h600), 0, 0); commit();
      drive(1, gen_inst(), XLEN'(32'h604), 0, 0); commit();
      drive(0, '0, '0, 0, 0);
      asserts++;
      if (count_o !== CW'(2)) begin fails++; $display("FAIL areset_pre_count: got %0d want 2", count_o); end
      #2 rst = 1'b1;
      #1;
      asserts++;
      if (count_o !== '0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || obs !== '0) begin
         fails++;
         $display("FAIL areset_immediate: count %0d valid %b ready %b data %h want 0 0 1 0",
                  count_o, out_valid_o, in_ready_o, obs);
      end
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_random();
      logic v, rdy, fl;
      for (int cyc = 0; cyc < 400; cyc++) begin
         v   = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         fl  = ($urandom_range(0, 19) == 0);
         drive(v, gen_inst(), XLEN'($urandom()), rdy, fl);
         asserts++;
         if (obs !== exp_head()) begin fails++; $display("FAIL random_entry: cyc %0d got %h want %h", cyc, obs, exp_head()); end
         asserts++;
         if (count_o !== CW'(exp_q.size()) || out_valid_o !== (exp_q.size() != 0)
             || in_ready_o !== (exp_q.size() < DEPTH)) begin
            fails++;
            $display("FAIL random_status: cyc %0d count %0d valid %b ready %b want count %0d",
                     cyc, count_o, out_valid_o, in_ready_o, exp_q.size());
         end
         commit();
      end
      for (int i = 0; i < DEPTH + 1; i++) begin
         drive(0, '0, '0, 1, 0);
         commit();
      end
      drive(0, '0, '0, 0, 0);
      asserts++;
      if (count_o !== '0) begin fails++; $display("FAIL random_drain: got count %0d want 0", count_o); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_addi();
      test_branch();
      test_full();
      test_stream();
      test_flush();
      test_illegal();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
